// File: rtl/mult_channel_array.sv
// Per-lane signed multiply stage: pops vec/mat pairs, multiplies in a fixed-depth pipeline, optionally
// accumulates row sums with saturation, and queues results in a private credit-protected output FIFO.
module mult_channel_array #(
  parameter int CHANNELS    = 4,
  parameter int VAL_BITS    = 16,
  parameter int ACC_BITS    = 40,
  parameter int FIFO_DEPTH  = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*VAL_BITS-1:0] vec,
  input  logic [CHANNELS-1:0]          vec_fifo_empty,
  output logic [CHANNELS-1:0]          vec_fifo_read,
  input  logic [CHANNELS*VAL_BITS-1:0] mat,
  input  logic [CHANNELS-1:0]          mat_last,
  input  logic [CHANNELS-1:0]          mat_fifo_empty,
  output logic [CHANNELS-1:0]          mat_fifo_read,
  input  logic [CHANNELS-1:0]          acc_mode,
  output logic [CHANNELS*ACC_BITS-1:0] mult,
  output logic [CHANNELS-1:0]          mult_fifo_empty,
  input  logic [CHANNELS-1:0]          mult_fifo_read,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          ovf
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int OCC_BITS = CNT_BITS + 3;
  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic signed [VAL_BITS-1:0]   vec_val;
      logic signed [VAL_BITS-1:0]   mat_val;
      logic signed [2*VAL_BITS-1:0] raw_product;
      logic [ACC_BITS-1:0]          product;

      logic [PIPE_STAGES-1:0]               pipe_valid_reg;
      logic [PIPE_STAGES-1:0]               pipe_last_reg;
      logic [PIPE_STAGES-1:0]               pipe_mode_reg;
      logic [PIPE_STAGES-1:0][ACC_BITS-1:0] pipe_data_reg;

      logic                mode_reg;
      logic                open_reg;
      logic                sat_hold_reg;
      logic                ovf_reg;
      logic [ACC_BITS-1:0] acc_reg;

      logic [ACC_BITS-1:0] mem [FIFO_DEPTH];
      logic [PTR_BITS-1:0] wr_ptr_reg;
      logic [PTR_BITS-1:0] rd_ptr_reg;
      logic [CNT_BITS-1:0] count_reg;

      logic [OCC_BITS-1:0] occupancy;
      logic                credit_ok;
      logic                fire;
      logic                lane_busy;
      logic                eff_mode;
      logic                end_valid;
      logic                end_last;
      logic                end_mode;
      logic [ACC_BITS-1:0] end_data;
      logic [ACC_BITS:0]   wide_sum;
      logic                sum_ovf;
      logic [ACC_BITS-1:0] sum_val;
      logic [ACC_BITS-1:0] wr_data;
      logic                wr_en;
      logic                rd_en;
      logic                acc_step;

      assign vec_val     = vec[gi*VAL_BITS +: VAL_BITS];
      assign mat_val     = mat[gi*VAL_BITS +: VAL_BITS];
      assign raw_product = vec_val * mat_val;
      assign product     = ACC_BITS'(raw_product);

      // Every in-flight product and an open row each reserve one output slot.
      always_comb begin
        occupancy = OCC_BITS'(count_reg) + OCC_BITS'(open_reg);
        for (int k = 0; k < PIPE_STAGES; k++) begin
          occupancy = occupancy + OCC_BITS'(pipe_valid_reg[k]);
        end
      end

      assign credit_ok = occupancy < OCC_BITS'(FIFO_DEPTH);
      assign fire      = ~vec_fifo_empty[gi] & ~mat_fifo_empty[gi] & ~rst & credit_ok;
      assign lane_busy = (|pipe_valid_reg) | open_reg;
      assign eff_mode  = lane_busy ? mode_reg : acc_mode[gi];

      assign end_valid = pipe_valid_reg[PIPE_STAGES-1];
      assign end_last  = pipe_last_reg[PIPE_STAGES-1];
      assign end_mode  = pipe_mode_reg[PIPE_STAGES-1];
      assign end_data  = pipe_data_reg[PIPE_STAGES-1];

      // One extra bit exposes signed overflow of the running sum.
      assign wide_sum = {acc_reg[ACC_BITS-1], acc_reg} + {end_data[ACC_BITS-1], end_data};
      assign sum_ovf  = wide_sum[ACC_BITS] ^ wide_sum[ACC_BITS-1];
      assign sum_val  = sat_hold_reg ? acc_reg :
                        sum_ovf      ? (wide_sum[ACC_BITS] ? ACC_MIN : ACC_MAX) :
                                       wide_sum[ACC_BITS-1:0];

      assign acc_step = end_valid & end_mode;
      assign wr_en    = end_valid & (~end_mode | end_last);
      assign wr_data  = end_mode ? sum_val : end_data;
      assign rd_en    = mult_fifo_read[gi] & (count_reg != '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_valid_reg <= '0;
          pipe_last_reg  <= '0;
          pipe_mode_reg  <= '0;
          pipe_data_reg  <= '0;
          mode_reg       <= 1'b0;
        end else begin
          pipe_valid_reg[0] <= fire;
          pipe_last_reg[0]  <= mat_last[gi];
          pipe_mode_reg[0]  <= eff_mode;
          pipe_data_reg[0]  <= product;
          for (int k = 1; k < PIPE_STAGES; k++) begin
            pipe_valid_reg[k] <= pipe_valid_reg[k-1];
            pipe_last_reg[k]  <= pipe_last_reg[k-1];
            pipe_mode_reg[k]  <= pipe_mode_reg[k-1];
            pipe_data_reg[k]  <= pipe_data_reg[k-1];
          end
          if (fire) begin
            mode_reg <= eff_mode;
          end
        end
      end

      // Saturation is held for the rest of the row; the flag outlives the row.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg      <= '0;
          open_reg     <= 1'b0;
          sat_hold_reg <= 1'b0;
          ovf_reg      <= 1'b0;
        end else begin
          if (acc_step) begin
            if (end_last) begin
              acc_reg      <= '0;
              open_reg     <= 1'b0;
              sat_hold_reg <= 1'b0;
            end else begin
              acc_reg      <= sum_val;
              open_reg     <= 1'b1;
              sat_hold_reg <= sat_hold_reg | sum_ovf;
            end
          end
          ovf_reg <= ovf_reg | (acc_step & ~sat_hold_reg & sum_ovf);
        end
      end

      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[wr_ptr_reg] <= wr_data;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          count_reg <= count_reg + CNT_BITS'(wr_en) - CNT_BITS'(rd_en);
        end
      end

      assign vec_fifo_read[gi]               = fire;
      assign mat_fifo_read[gi]               = fire;
      assign mult_fifo_empty[gi]             = (count_reg == '0);
      assign mult[gi*ACC_BITS +: ACC_BITS]   = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
      assign busy[gi]                        = lane_busy;
      assign ovf[gi]                         = ovf_reg;
    end
  endgenerate

endmodule
